// File: rtl/mat_pkg.sv
// Shared definitions for the matrix loader and the determinant stage that
// consumes its packed output.
package mat_pkg;

  // Largest supported matrix order and element width (signed two's complement)
  localparam int MAX_N = 5;
  localparam int W     = 8;

  // Width of the densely packed matrix vector handed to the determinant stage
  localparam int MAT_W = MAX_N * MAX_N * W;

  // Element index counter width: covers 0..MAX_N*MAX_N-1
  localparam int IDX_W = 5;

  // Legal matrix orders accepted on a start request
  localparam logic [7:0] TAM_MIN = 8'd2;
  localparam logic [7:0] TAM_MAX = 8'd5;

  // Loader state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } estado_t;

  // True when a requested order lies inside the supported range
  function automatic logic tam_valido(input logic [7:0] t);
    return (t >= TAM_MIN) && (t <= TAM_MAX);
  endfunction

  // Number of elements of a square matrix of order t, truncated to the
  // index width (orders are range-checked before this is used)
  function automatic logic [IDX_W-1:0] num_elem(input logic [7:0] t);
    logic [15:0] quad;
    quad = t * t;
    return quad[IDX_W-1:0];
  endfunction

endpackage

// File: rtl/carrega_matriz.sv
// Matrix loader: accepts a matrix order with a start pulse, collects
// order*order signed elements in row-major order through a valid/ready
// stream, and presents the packed matrix to the determinant stage until
// it is acknowledged.
module carrega_matriz #(
  parameter int MAX_N = 5,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [7:0]             tamanho_in,
  input  logic                   in_valid,
  input  logic [W-1:0]           in_data,
  output logic                   in_ready,
  output logic [MAX_N*MAX_N*W-1:0] matriz1,
  output logic [7:0]             tamanho,
  output logic                   matriz_valid,
  input  logic                   matriz_ack,
  output logic                   busy,
  output logic                   erro
);

  import mat_pkg::*;

  localparam int LW = MAX_N * MAX_N * W;

  estado_t                r_estado;
  estado_t                w_prox;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       r_alvo;
  logic [LW-1:0]          r_matriz1;
  logic [7:0]             r_tamanho;
  logic                   r_erro;

  logic                   w_req_ok;
  logic                   w_req_bad;
  logic                   w_xfer;
  logic                   w_ultimo;

  // A start request is only looked at in IDLE; anything else ignores it
  assign w_req_ok  = (r_estado == ST_IDLE) && start &&  tam_valido(tamanho_in);
  assign w_req_bad = (r_estado == ST_IDLE) && start && !tam_valido(tamanho_in);

  // Handshake: an element moves when the producer offers and we are loading
  assign w_xfer   = in_valid && (r_estado == ST_LOAD);
  assign w_ultimo = (r_idx == (r_alvo - 1'b1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= ST_IDLE;
    end else begin
      r_estado <= w_prox;
    end
  end

  // Next-state logic: IDLE -> LOAD on a legal start, LOAD -> HOLD on the
  // last element, HOLD -> IDLE on acknowledge
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      ST_IDLE: begin
        if (w_req_ok) begin
          w_prox = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_xfer && w_ultimo) begin
          w_prox = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (matriz_ack) begin
          w_prox = ST_IDLE;
        end
      end
      default: begin
        w_prox = ST_IDLE;
      end
    endcase
  end

  // Order latch, element target and one-cycle error pulse on rejected orders
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tamanho <= 8'd0;
      r_alvo    <= '0;
      r_erro    <= 1'b0;
    end else begin
      r_erro <= w_req_bad;
      if (w_req_ok) begin
        r_tamanho <= tamanho_in;
        r_alvo    <= num_elem(tamanho_in);
      end
    end
  end

  // Element index: cleared on a new load, advanced on every transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_req_ok) begin
      r_idx <= '0;
    end else if (w_xfer) begin
      r_idx <= r_idx + 1'b1;
    end
  end

  // Packed matrix storage: cleared on a new load so unused upper elements
  // read as zero, then filled densely in arrival order; data is stored raw
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_matriz1 <= '0;
    end else if (w_req_ok) begin
      r_matriz1 <= '0;
    end else if (w_xfer) begin
      r_matriz1[int'(r_idx)*W +: W] <= in_data;
    end
  end

  assign in_ready     = (r_estado == ST_LOAD);
  assign busy         = (r_estado != ST_IDLE);
  assign matriz_valid = (r_estado == ST_HOLD);
  assign matriz1      = r_matriz1;
  assign tamanho      = r_tamanho;
  assign erro         = r_erro;

endmodule

// File: doc/carrega_matriz.md
CARREGA_MATRIZ -- requirements
Module: carrega_matriz

Interface
REQ-001 Parameter MAX_N, default 5: largest supported matrix order.
REQ-002 Parameter W, default 8: element width in bits, signed two's complement.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin loading a matrix.
REQ-006 tamanho_in  input  8  matrix order requested with start.
REQ-007 in_valid  input  1  element byte on in_data is valid.
REQ-008 in_data  input  W  element, row-major order.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 matriz1  output  MAX_N*MAX_N*W (200)  packed matrix for the determinant stage.
REQ-011 tamanho  output  8  latched order, stable while matriz_valid=1.
REQ-012 matriz_valid  output  1  matrix complete and stable.
REQ-013 matriz_ack  input  1  consumer has taken the result; releases the matrix.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 erro  output  1  one-cycle pulse: illegal tamanho_in rejected.

Function
REQ-016 FSM states: IDLE, LOAD, HOLD.
REQ-017 IDLE: start=1 with tamanho_in in 2..5 -> latch tamanho, clear matriz1 to 0 and idx to 0, go to LOAD.
REQ-018 IDLE: start=1 with tamanho_in outside 2..5 -> erro=1 on the next cycle, stay in IDLE, tamanho and matriz1 unchanged.
REQ-019 start is ignored in LOAD and HOLD; no error is raised.
REQ-020 in_ready=1 only in LOAD.
REQ-021 Transfer occurs on a cycle with in_valid=1 and in_ready=1; in_data is written to matriz1[idx*W +: W]; idx increments by 1.
REQ-022 idx is a 5-bit counter covering 0..24; the target count is tamanho*tamanho, computed once at latch time.
REQ-023 Element (i,j) lands at bit offset (i*tamanho+j)*W, densely packed; bits at and above tamanho*tamanho*W remain 0.
REQ-024 Transfer of element number tamanho*tamanho-1 -> next state HOLD; matriz_valid=1 on the following cycle; no extra latency.
REQ-025 in_valid=0 in LOAD stalls without timeout; idx and matriz1 hold.
REQ-026 HOLD: matriz1, tamanho and matriz_valid are stable until matriz_ack=1, which gives the clocked determinant sub-stages unlimited settle time.
REQ-027 HOLD with matriz_ack=1 -> IDLE next cycle; matriz_valid drops; matriz1 and tamanho retain their last values.
REQ-028 matriz_ack outside HOLD is ignored.
REQ-029 A start in the same cycle as the matriz_ack that leaves HOLD is ignored, because start is only sampled in IDLE.
REQ-030 in_data values are stored unmodified; no saturation or sign processing takes place in this block.

Reset
REQ-031 rst_n low asynchronously forces: state=IDLE, idx=0, matriz1=0, tamanho=0, matriz_valid=0, in_ready=0, busy=0, erro=0.
REQ-032 Reset during LOAD or HOLD discards the partial or complete matrix; after release the block needs a new start.

Structure
REQ-033 Shared package mat_pkg holds MAX_N, W, state encoding, the TAM_MIN=2 and TAM_MAX=5 constants and the packed-vector width; the determinant stage uses the same package.
REQ-034 Single module with no sub-modules; the element write is an indexed part-select driven by idx.

Verification
REQ-035 start, tamanho_in=2, bytes 3,1,2,4 back-to-back -> matriz_valid 5 cycles after start; matriz1[31:0]=0x04020103; upper bits 0; tamanho=2.
REQ-036 tamanho_in=3, bytes 1..9 with in_valid dropped every other cycle -> exactly 9 transfers; matriz1[71:0] holds 0x09..0x01 row-major; in_ready low in HOLD.
REQ-037 tamanho_in=5, 25 bytes of 0x80 -> all 200 bits = 0x80 repeated; matriz_valid held through a 50-cycle ack delay; ack -> IDLE next cycle.
REQ-038 tamanho_in=6, then tamanho_in=1 -> one erro pulse each; busy stays 0; outputs unchanged.
REQ-039 rst_n low after 7 of 16 bytes (tamanho=4) -> all outputs 0 immediately; a new 2x2 load then completes correctly with zeros above bit 31.
REQ-040 start pulses during LOAD and HOLD, and matriz_ack during LOAD -> no effect on idx, state or data.
